// File: rtl/clk_div_gen.sv
// clk_div_gen: N_CH independent programmable clock dividers sharing one clock.
// Each channel produces a registered square wave plus a one-cycle tick at the
// start of every period. Period updates are shadowed and take effect only at the
// channel's period boundary. cfg_sync restarts every channel in phase.
module clk_div_gen #(
    parameter int                     N_CH     = 2,
    parameter int                     CNT_W    = 8,
    parameter logic [N_CH*CNT_W-1:0]  DIV_INIT = {8'd5, 8'd10},
    parameter int                     CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_sync,
    output logic [N_CH-1:0]   clk_out,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pend
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Per-channel state: phase index, active period, shadowed period.
    logic [CNT_W-1:0] r_cnt  [N_CH];
    logic [CNT_W-1:0] r_cur  [N_CH];
    logic [CNT_W-1:0] r_pdiv [N_CH];
    logic [N_CH-1:0]  r_pend;
    logic [N_CH-1:0]  r_clk_out;
    logic [N_CH-1:0]  r_tick;
    // Low until the first edge after reset; that edge is forced to be k=0.
    logic             r_run;

    logic [CNT_W-1:0] w_cnt_nx  [N_CH];
    logic [CNT_W-1:0] w_cur_nx  [N_CH];
    logic [CNT_W-1:0] w_pdiv_nx [N_CH];
    logic [N_CH-1:0]  w_pend_nx;
    logic [N_CH-1:0]  w_clk_nx;
    logic [N_CH-1:0]  w_tick_nx;
    logic [N_CH-1:0]  w_sel;
    logic [N_CH-1:0]  w_bnd;

    // Next-state for every channel: sync, start-up, boundary update, phase advance.
    // Outputs are decoded from the next state so the registered outputs already
    // describe the phase entered on this edge.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            // Out-of-range cfg_ch matches no channel, so such writes vanish.
            w_sel[i]     = cfg_we && (cfg_ch == CH_W'(i));
            // D of 0 or 1 makes every edge a boundary.
            w_bnd[i]     = (r_cur[i] <= ONE) || (r_cnt[i] == (r_cur[i] - ONE));
            w_cnt_nx[i]  = r_cnt[i];
            w_cur_nx[i]  = r_cur[i];
            w_pdiv_nx[i] = r_pdiv[i];
            w_pend_nx[i] = r_pend[i];

            if (cfg_sync) begin
                // A write coinciding with sync bypasses the shadow register.
                w_cnt_nx[i]  = '0;
                w_pend_nx[i] = 1'b0;
                if (w_sel[i]) begin
                    w_cur_nx[i] = cfg_div;
                end else if (r_pend[i]) begin
                    w_cur_nx[i] = r_pdiv[i];
                end
            end else begin
                if (!r_run) begin
                    w_cnt_nx[i] = '0;
                end else if (w_bnd[i]) begin
                    w_cnt_nx[i] = '0;
                    if (r_pend[i]) begin
                        w_cur_nx[i]  = r_pdiv[i];
                        w_pend_nx[i] = 1'b0;
                    end
                end else begin
                    w_cnt_nx[i] = r_cnt[i] + ONE;
                end
                // Applied after the boundary decision: a write landing on a
                // boundary edge waits for the next one.
                if (w_sel[i]) begin
                    w_pdiv_nx[i] = cfg_div;
                    w_pend_nx[i] = 1'b1;
                end
            end

            w_clk_nx[i]  = (w_cur_nx[i] > ONE) && (w_cnt_nx[i] < (w_cur_nx[i] >> 1));
            w_tick_nx[i] = (w_cur_nx[i] != '0) && (w_cnt_nx[i] == '0);
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i]  <= '0;
                r_cur[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
                r_pdiv[i] <= '0;
            end
            r_pend    <= '0;
            r_clk_out <= '0;
            r_tick    <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i]  <= w_cnt_nx[i];
                r_cur[i]  <= w_cur_nx[i];
                r_pdiv[i] <= w_pdiv_nx[i];
            end
            r_pend    <= w_pend_nx;
            r_clk_out <= w_clk_nx;
            r_tick    <= w_tick_nx;
        end
    end

    // Marks that the post-reset start edge has occurred.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign pend    = r_pend;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen. The reference model tracks, per channel,
// the absolute edge index at which the current period began and derives the
// phase with modular arithmetic.
`timescale 1ns/1ps
module tb_clk_div_gen;

    localparam int N   = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;
    localparam logic [N*CW-1:0] INIT = {8'd3, 8'd5, 8'd10};

    logic           clk_in = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_sync;
    logic [N-1:0]   clk_out;
    logic [N-1:0]   tick;
    logic [N-1:0]   pend;

    clk_div_gen #(
        .N_CH     (N),
        .CNT_W    (CW),
        .DIV_INIT (INIT)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_sync (cfg_sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .pend     (pend)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [N-1:0] clk;
        logic [N-1:0] tck;
        logic [N-1:0] pnd;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   mon_idx  = 0;

    // Reference model state.
    int mD  [N];
    int mP  [N];
    int mPD [N];
    int mSt [N];
    int n;
    bit started;

    function automatic void chk(input string name, input int cyc,
                                input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            mD[c]  = int'(INIT[c*CW +: CW]);
            mP[c]  = 0;
            mPD[c] = 0;
            mSt[c] = 0;
        end
        n       = 0;
        started = 1'b0;
    endfunction

    function automatic void model_edge(input bit we, input int ch, input int dv, input bit sy);
        bit first;
        bit bnd;
        first = !started;
        if (first) begin
            started = 1'b1;
            n = 0;
        end else begin
            n++;
        end
        for (int c = 0; c < N; c++) begin
            if (sy) begin
                if (we && ch == c) mD[c] = dv;
                else if (mP[c] != 0) mD[c] = mPD[c];
                mP[c]  = 0;
                mSt[c] = n;
            end else begin
                bnd = (mD[c] <= 1) || (((n - mSt[c]) % mD[c]) == 0);
                if (!first && bnd && mP[c] != 0) begin
                    mD[c]  = mPD[c];
                    mP[c]  = 0;
                    mSt[c] = n;
                end
                if (we && ch == c) begin
                    mPD[c] = dv;
                    mP[c]  = 1;
                end
            end
        end
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   k;
        for (int c = 0; c < N; c++) begin
            k = (mD[c] == 0) ? 0 : ((n - mSt[c]) % mD[c]);
            e.clk[c] = started && (mD[c] >= 2) && (k < mD[c] / 2);
            e.tck[c] = started && (mD[c] >= 1) && (k == 0);
            e.pnd[c] = (mP[c] != 0);
        end
        return e;
    endfunction

    function automatic bit next_is_bnd(input int c);
        if (!started) return 1'b0;
        if (mD[c] <= 1) return 1'b1;
        return (((n + 1 - mSt[c]) % mD[c]) == 0);
    endfunction

    // One clock of stimulus; the expectation for the coming edge is queued.
    task automatic step(input bit r, input bit we, input int ch, input int dv, input bit sy);
        bit   rose;
        exp_t e;
        rose     = r && !rst;
        rst      = r;
        cfg_we   = we;
        cfg_ch   = CHW'(ch);
        cfg_div  = CW'(dv);
        cfg_sync = sy;
        if (rose) begin
            #1;
            chk("rst_async_clk_out", mon_idx, clk_out, '0);
            chk("rst_async_tick", mon_idx, tick, '0);
            chk("rst_async_pend", mon_idx, pend, '0);
        end
        if (r) model_reset();
        else   model_edge(we, ch, dv, sy);
        e = predict();
        @(posedge clk_in);
        sbq.push_back(e);
        @(negedge clk_in);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a registered output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("clk_out", mon_idx, clk_out, e.clk);
                chk("tick", mon_idx, tick, e.tck);
                chk("pend", mon_idx, pend, e.pnd);
                mon_idx++;
            end
        end
    end

    initial begin
        int guard;
        bit rnd_we;
        bit rnd_sy;
        bit rnd_rst;
        int rnd_ch;
        int rnd_dv;

        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_sync = 1'b0;
        model_reset();
        @(negedge clk_in);
        #1;

        // Reset defaults.
        repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);
        idle(40);

        // Odd period written mid-period.
        idle(3);
        step(1'b0, 1'b1, 0, 7, 1'b0);
        idle(30);

        // Last write wins.
        step(1'b0, 1'b1, 0, 4, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 0, 6, 1'b0);
        idle(20);

        // Write landing exactly on a boundary edge.
        guard = 0;
        while (!next_is_bnd(0) && guard < 300) begin
            idle(1);
            guard++;
        end
        step(1'b0, 1'b1, 0, 8, 1'b0);
        idle(30);

        // Special periods on ch1.
        step(1'b0, 1'b1, 1, 0, 1'b0);
        idle(8);
        step(1'b0, 1'b1, 1, 1, 1'b0);
        idle(6);
        step(1'b0, 1'b1, 1, 2, 1'b0);
        idle(10);

        // Sync with a simultaneous write, channels out of phase.
        step(1'b0, 1'b1, 0, 10, 1'b0);
        step(1'b0, 1'b1, 1, 5, 1'b0);
        idle(23);
        step(1'b0, 1'b1, 2, 9, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1, 6, 1'b1);
        idle(20);

        // Reset while an update is pending.
        step(1'b0, 1'b1, 0, 3, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        idle(25);

        // Out-of-range channel write is ignored.
        step(1'b0, 1'b1, 3, 1, 1'b0);
        idle(15);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rnd_we  = ($urandom_range(0, 11) == 0);
            rnd_sy  = ($urandom_range(0, 79) == 0);
            rnd_rst = ($urandom_range(0, 399) == 0);
            rnd_ch  = int'($urandom_range(0, 3));
            rnd_dv  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 12))
                                                  : int'($urandom_range(0, 255));
            step(rnd_rst, rnd_we, rnd_ch, rnd_dv, rnd_sy);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock-divider generator. It derives N_CH divided square-wave outputs from one fabric clock. Each output has its own runtime-programmable period, a one-cycle tick strobe and glitch-free period updates that take effect only at period boundaries. It also has a synchronous restart that phase-aligns all channels. It feeds the LCD init/timing logic and any other block that needs slow strobes derived from the 100 MHz input.

## Interface
Parameters:
- N_CH, 2: number of output channels (≥1).
- CNT_W, 8: width of the period counter and of cfg_div; maximum period is 2^CNT_W−1 cycles.
- DIV_INIT, {8'd5, 8'd10}: packed N_CH×CNT_W reset periods; channel 0 is in the LSBs. The defaults give 10 MHz on ch0 and 20 MHz on ch1 from 100 MHz.
- CH_W, max(1, clog2(N_CH)): width of cfg_ch (derived).

Ports:
- clk_in  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write strobe for a period update; always accepted, no back-pressure.
- cfg_ch  in  CH_W  target channel; if cfg_ch ≥ N_CH the write is ignored.
- cfg_div  in  CNT_W  new period D in clk_in cycles.
- cfg_sync  in  1  restart all channels in phase at the next edge.
- clk_out  out  N_CH  divided square waves, registered.
- tick  out  N_CH  one-cycle pulse in the first cycle of each period, registered.
- pend  out  N_CH  a period update is waiting for the channel's boundary.

## Operation
Per-channel state:
- cnt: phase index k.
- cur_div: active period D.
- pend_div / pend flag: shadowed update.

Period coding:
- D ≥ 2: k runs 0..D−1 and wraps.
  - clk_out=1 while k < H, where H = floor(D/2); clk_out=0 for the remaining D−H cycles. Odd D gives the extra cycle to the low phase.
  - tick=1 only when k=0.
  - The edge where k goes from D−1 to 0 is the boundary edge.
- D = 1: clk_out=0 constantly; tick=1 every cycle. Every edge is a boundary.
- D = 0: channel off. clk_out=0, tick=0, k held at 0. Every edge is a boundary.

Update:
- cfg_we on edge E loads pend_div[cfg_ch] and sets pend.
- On a boundary edge with pend=1: cur_div←pend_div, k←0, pend←0. The outputs in the following cycle already follow the new D (k=0 of the new period).
- A write landing on a boundary edge is not applied on that edge. The boundary decision uses the pend/pend_div values held before E; the new write waits for the next boundary.
- A second write before the boundary overwrites pend_div; the last write wins.

Sync:
- cfg_sync on edge E: for every channel, apply pend_div if pend=1 (pend←0), set k←0, and output period start (tick=1; clk_out=1 if D≥2).
- If cfg_we arrives in the same cycle as cfg_sync, that write is applied immediately on E for its channel and does not set pend.
- cfg_sync has priority over boundary processing.

Reset (asynchronous, rst=1): cnt=0, cur_div=DIV_INIT, pend=0, pend_div=0, clk_out=0, tick=0. The outputs hold those values while rst is high. Reset mid-period discards the phase and any pending update.

## Timing
- The first clk_in edge with rst low is period-start edge k=0. Channels with D≥2 show clk_out=1, tick=1 after that edge, a 1-cycle latency from reset release. Channels with D=1 show tick=1 and clk_out=0. Channels with D=0 show nothing.
- All outputs are flops; there are no combinational paths from inputs to outputs.
- Update latency: the value is visible on pend 1 cycle after cfg_we. It becomes active at the first boundary edge strictly after the write edge.
- A period is exactly D cycles, steady state, for every D in 1..2^CNT_W−1. Counter compare is on cur_div−1 at CNT_W bits, with no overflow.
- Channels are independent apart from sharing cfg_sync.

## Test plan
- Reset defaults: release rst, run 40 cycles. Required: ch0 high 5 / low 5, tick every 10 cycles; ch1 high 2 / low 3, tick every 5 cycles; both ticks coincide on the first edge.
- Odd period: write ch0 D=7 mid-period. Required: pend0=1 until the next boundary, then high 3 / low 4 cycles; no truncated or runt pulse on clk_out[0] across the change.
- Last-wins and boundary collision: write D=4 then D=6 before the boundary → D=6 applied. Write D=8 exactly on a boundary edge → applied one full old period later.
- Special periods: D=0 → clk_out=0, tick=0, pend clears after 1 edge. D=1 → tick=1 every cycle, clk_out=0. Then D=2 → a 1/1 square wave starting the next cycle.
- Sync with a simultaneous write: run ch0 D=10 and ch1 D=5 out of phase, then pulse cfg_sync with cfg_we ch1 D=6. Required: next cycle tick=2'b11, clk_out=2'b11; ch1 period 6, pend=0.
- Mid-operation reset: assert rst asynchronously with a pending update. Required: outputs 0 immediately and pend=0; after release, the DIV_INIT periods restart from k=0. A write to cfg_ch ≥ N_CH (for N_CH=3 builds) changes nothing.
